// File: rtl/itree_channel_scheduler.sv
// Round-robin scheduler time-sharing one isolation-tree anomaly detector across
// NUM_CH sensor byte FIFOs, with a tree flush before each burst and per-channel anomaly flags.
module itree_channel_scheduler #(
  parameter int NUM_CH    = 4,
  parameter int BURST_LEN = 32,
  parameter int STALL_MAX = 16,
  parameter int DRAIN_CYC = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [8*NUM_CH-1:0]       ch_data,
  input  logic [NUM_CH-1:0]         ch_valid,
  output logic [NUM_CH-1:0]         ch_pop,
  output logic [7:0]                tree_data,
  output logic                      tree_valid,
  output logic                      tree_rst_n,
  input  logic                      tree_anomaly,
  output logic [NUM_CH-1:0]         anomaly_flags,
  input  logic [NUM_CH-1:0]         anomaly_clear,
  output logic [$clog2(NUM_CH)-1:0] grant_ch,
  output logic                      busy,
  output logic                      burst_done
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam int BC_W = $clog2(BURST_LEN + 1);
  localparam int SC_W = $clog2(STALL_MAX + 1);
  localparam int DC_W = $clog2(DRAIN_CYC + 1);

  typedef enum logic [1:0] {IDLE, FLUSH, STREAM, DRAIN} state_t;

  state_t            state, next_state;
  logic [CH_W-1:0]   last_grant, pick;
  logic [BC_W-1:0]   byte_cnt;
  logic [SC_W-1:0]   stall_cnt;
  logic [DC_W-1:0]   drain_cnt;
  logic [7:0]        sel_data;
  logic              sel_valid, pop, drain_last;
  logic [NUM_CH-1:0] attr_mask;

  // Scan from the farthest candidate down so the nearest valid one after last_grant wins.
  always_comb begin
    pick = '0;
    for (int unsigned k = NUM_CH; k >= 1; k--) begin
      if (ch_valid[CH_W'((32'(last_grant) + k) % NUM_CH)])
        pick = CH_W'((32'(last_grant) + k) % NUM_CH);
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (grant_ch == CH_W'(i)) begin
        sel_data  = ch_data[8*i +: 8];
        sel_valid = ch_valid[i];
      end
    end
  end

  assign pop        = (state == STREAM) && sel_valid;
  assign drain_last = (drain_cnt == DC_W'(DRAIN_CYC - 1));

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (|ch_valid) next_state = FLUSH;
      FLUSH:   next_state = STREAM;
      STREAM:  if (pop ? (byte_cnt == BC_W'(BURST_LEN - 1))
                       : (stall_cnt == SC_W'(STALL_MAX - 1))) next_state = DRAIN;
      DRAIN:   if (drain_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ch_pop = '0;
    if (pop) ch_pop[grant_ch] = 1'b1;
    busy       = (state != IDLE);
    burst_done = (state == DRAIN) && drain_last;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant <= CH_W'(NUM_CH - 1);
      grant_ch   <= '0;
      byte_cnt   <= '0;
      stall_cnt  <= '0;
      drain_cnt  <= '0;
      tree_data  <= '0;
      tree_valid <= 1'b0;
      tree_rst_n <= 1'b0;
    end else begin
      tree_rst_n <= (next_state != FLUSH);
      tree_valid <= pop;
      if (pop) tree_data <= sel_data;
      if (state == IDLE && |ch_valid) grant_ch <= pick;
      if (burst_done) last_grant <= grant_ch;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
      case (state)
        FLUSH: begin
          byte_cnt  <= '0;
          stall_cnt <= '0;
        end
        STREAM: begin
          if (pop) begin
            byte_cnt  <= byte_cnt + 1'b1;
            stall_cnt <= '0;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    attr_mask = '0;
    if (tree_anomaly && (state == STREAM || state == DRAIN)) attr_mask[grant_ch] = 1'b1;
  end

  // A new attribution beats a simultaneous write-1-to-clear.
  always_ff @(posedge clk) begin
    if (!reset) anomaly_flags <= '0;
    else        anomaly_flags <= (anomaly_flags & ~anomaly_clear) | attr_mask;
  end

endmodule

// File: tb/tb_itree_channel_scheduler.sv
// Directed bench for itree_channel_scheduler: timeline table for one channel plus
// hand-written round-robin, stall, anomaly, collision and mid-burst reset sequences.
module tb_itree_channel_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ch_data;
  logic [3:0]  ch_valid, ch_pop, anomaly_flags, anomaly_clear;
  logic [7:0]  tree_data;
  logic        tree_valid, tree_rst_n, tree_anomaly, busy, burst_done;
  logic [1:0]  grant_ch;

  itree_channel_scheduler #(.NUM_CH(4), .BURST_LEN(32), .STALL_MAX(16), .DRAIN_CYC(2)) dut (
    .clk(clk), .reset(reset), .ch_data(ch_data), .ch_valid(ch_valid), .ch_pop(ch_pop),
    .tree_data(tree_data), .tree_valid(tree_valid), .tree_rst_n(tree_rst_n),
    .tree_anomaly(tree_anomaly), .anomaly_flags(anomaly_flags), .anomaly_clear(anomaly_clear),
    .grant_ch(grant_ch), .busy(busy), .burst_done(burst_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       t;
    bit       anom;
    bit [3:0] clr;
    bit [3:0] pop;
    bit       busy;
    bit       trst;
    bit       tval;
    bit       bdone;
    bit [1:0] grant;
    bit [3:0] flags;
  } vec_t;

  localparam int NV = 20;
  vec_t tab [NV];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int avail [4];
  int rd [4];
  int pops [4];
  logic [3:0] last_pop;
  logic [7:0] pop_byte, exp_data;
  logic       exp_tval;

  function automatic vec_t mk(int t, bit anom, bit [3:0] clr, bit [3:0] pop, bit b, bit trst,
                              bit tval, bit bdone, bit [1:0] grant, bit [3:0] flags);
    vec_t v;
    v.t = t; v.anom = anom; v.clr = clr; v.pop = pop; v.busy = b; v.trst = trst;
    v.tval = tval; v.bdone = bdone; v.grant = grant; v.flags = flags;
    return v;
  endfunction

  function automatic logic [7:0] byte_of(int c, int k);
    return 8'((c * 64 + (k % 64)) % 256);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got 0x%0h, want 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_fifos();
    for (int c = 0; c < 4; c++) begin
      ch_valid[c]        = (avail[c] > 0);
      ch_data[8*c +: 8]  = byte_of(c, rd[c]);
    end
  endtask

  // Consume last cycle's pops, present new FIFO heads, and predict the tree byte stream.
  task automatic begin_cycle();
    logic edge_rst;
    @(posedge clk);
    edge_rst = !reset;
    #1;
    cyc++;
    for (int c = 0; c < 4; c++) begin
      if (last_pop[c] && avail[c] > 0) begin
        rd[c]++;
        avail[c]--;
      end
    end
    drive_fifos();
    tree_anomaly  = 1'b0;
    anomaly_clear = '0;
    if (edge_rst) begin
      exp_tval = 1'b0;
      exp_data = '0;
    end else if (|last_pop) begin
      exp_tval = 1'b1;
      exp_data = pop_byte;
    end else begin
      exp_tval = 1'b0;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    chk("tree_valid", 32'(tree_valid), 32'(exp_tval));
    chk("tree_data", 32'(tree_data), 32'(exp_data));
    chk("pop_onehot", 32'($onehot0(ch_pop)), 32'd1);
    chk("pop_only_valid", 32'(ch_pop & ~ch_valid), 32'd0);
    chk("pop_only_grant", 32'(ch_pop & ~(4'b0001 << grant_ch)), 32'd0);
    last_pop = ch_pop;
    for (int c = 0; c < 4; c++) begin
      if (ch_pop[c]) begin
        pop_byte = byte_of(c, rd[c]);
        pops[c]++;
      end
    end
  endtask

  task automatic step_in(input logic anom, input logic [3:0] clr);
    begin_cycle();
    tree_anomaly  = anom;
    anomaly_clear = clr;
    sample();
  endtask

  task automatic step();
    step_in(1'b0, 4'h0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      avail[c] = 0;
      pops[c]  = 0;
    end
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tree_rst_n", 32'(tree_rst_n), 32'd0);
    chk("rst_flags", 32'(anomaly_flags), 32'd0);
    chk("rst_grant", 32'(grant_ch), 32'd0);
    chk("rst_burst_done", 32'(burst_done), 32'd0);
    chk("rst_pop", 32'(ch_pop), 32'd0);
    reset = 1'b1;
    step();
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog (cycle %0d): got timeout, want completion", cyc);
    $fatal(1);
  end

  initial begin
    int k, nflush, burst_pops, last_pop_cyc, done_cyc;
    bit found;
    int rr_exp [5] = '{0, 1, 2, 3, 0};

    //            t  anom  clr   pop   busy  trst  tval  bdone grant flags
    tab[0]  = mk( 0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'h0);
    tab[1]  = mk( 1, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'h0);
    tab[2]  = mk( 2, 1'b0, 4'h0, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'h0);
    tab[3]  = mk( 3, 1'b1, 4'h0, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 4'h0);
    tab[4]  = mk( 4, 1'b0, 4'h2, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 4'h2);
    tab[5]  = mk( 5, 1'b0, 4'h0, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 4'h0);
    tab[6]  = mk(33, 1'b0, 4'h0, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 4'h0);
    tab[7]  = mk(34, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 4'h0);
    tab[8]  = mk(35, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 4'h0);
    tab[9]  = mk(36, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 4'h0);
    tab[10] = mk(37, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 4'h0);
    tab[11] = mk(38, 1'b0, 4'h0, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'h0);
    tab[12] = mk(45, 1'b0, 4'h0, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 4'h0);
    tab[13] = mk(46, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 4'h0);
    tab[14] = mk(47, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'h0);
    tab[15] = mk(61, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'h0);
    tab[16] = mk(62, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 4'h0);
    tab[17] = mk(63, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 2'd1, 4'h0);
    tab[18] = mk(64, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 4'h0);
    tab[19] = mk(65, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 4'h0);

    reset = 1'b0; tree_anomaly = 1'b0; anomaly_clear = '0;
    ch_valid = '0; ch_data = '0;
    for (int c = 0; c < 4; c++) begin avail[c] = 0; rd[c] = 0; pops[c] = 0; end
    last_pop = '0; pop_byte = '0; exp_data = '0; exp_tval = 1'b0;

    // Single channel: ch1 with 40 bytes, timeline relative to t0.
    do_reset();
    avail[1] = 40;
    k = 0;
    for (int t = 0; t <= 65; t++) begin
      begin_cycle();
      if (k < NV && tab[k].t == t) begin
        tree_anomaly  = tab[k].anom;
        anomaly_clear = tab[k].clr;
      end
      sample();
      if (k < NV && tab[k].t == t) begin
        chk($sformatf("t%0d_pop", t), 32'(ch_pop), 32'(tab[k].pop));
        chk($sformatf("t%0d_busy", t), 32'(busy), 32'(tab[k].busy));
        chk($sformatf("t%0d_tree_rst_n", t), 32'(tree_rst_n), 32'(tab[k].trst));
        chk($sformatf("t%0d_tree_valid", t), 32'(tree_valid), 32'(tab[k].tval));
        chk($sformatf("t%0d_burst_done", t), 32'(burst_done), 32'(tab[k].bdone));
        chk($sformatf("t%0d_grant", t), 32'(grant_ch), 32'(tab[k].grant));
        chk($sformatf("t%0d_flags", t), 32'(anomaly_flags), 32'(tab[k].flags));
        k++;
      end
      if (t == 35) chk("single_burst1_pops", 32'(pops[1]), 32'd32);
    end
    chk("single_total_pops", 32'(pops[1]), 32'd40);

    // Round robin with all four channels permanently valid.
    do_reset();
    for (int c = 0; c < 4; c++) avail[c] = 1000;
    nflush = 0;
    burst_pops = 0;
    for (int n = 0; n < 200 && nflush < 5; n++) begin
      step();
      if (busy && !tree_rst_n) begin
        chk($sformatf("rr_grant%0d", nflush), 32'(grant_ch), 32'(rr_exp[nflush]));
        if (nflush > 0) chk("rr_burst_pops", 32'(burst_pops), 32'd32);
        burst_pops = 0;
        nflush++;
      end
      burst_pops += $countones(ch_pop);
    end
    chk("rr_flush_count", 32'(nflush), 32'd5);

    // Stall timeout: ch2 supplies only 5 bytes.
    do_reset();
    avail[2] = 5;
    last_pop_cyc = -1000;
    done_cyc = -1;
    for (int n = 0; n < 80 && done_cyc < 0; n++) begin
      step();
      if (ch_pop[2]) last_pop_cyc = cyc;
      if (burst_done) done_cyc = cyc;
    end
    chk("stall_pops", 32'(pops[2]), 32'd5);
    chk("stall_done_seen", 32'(done_cyc >= 0), 32'd1);
    chk("stall_gap", 32'(done_cyc - last_pop_cyc), 32'd18);
    step();
    chk("stall_idle", 32'(busy), 32'd0);

    // Anomaly in the second DRAIN cycle of a ch3 burst, then in IDLE.
    do_reset();
    avail[3] = 32;
    found = 0;
    for (int n = 0; n < 60 && !found; n++) begin
      step();
      if (burst_done) found = 1;
    end
    chk("anom_done_seen", 32'(found), 32'd1);
    chk("anom_done_grant", 32'(grant_ch), 32'd3);
    tree_anomaly = 1'b1;
    step();
    chk("anom_drain_flag", 32'(anomaly_flags), 32'h8);
    chk("anom_now_idle", 32'(busy), 32'd0);
    step_in(1'b1, 4'h0);
    step();
    chk("anom_idle_ignored", 32'(anomaly_flags), 32'h8);
    step_in(1'b0, 4'h8);
    step();
    chk("anom_clear3", 32'(anomaly_flags), 32'd0);

    // Set/clear collision on ch0 while streaming.
    avail[0] = 10;
    found = 0;
    for (int n = 0; n < 20 && !found; n++) begin
      step();
      if (ch_pop[0]) found = 1;
    end
    chk("coll_stream_seen", 32'(found), 32'd1);
    tree_anomaly = 1'b1;
    step();
    chk("coll_set", 32'(anomaly_flags), 32'h1);
    tree_anomaly  = 1'b1;
    anomaly_clear = 4'h1;
    step();
    chk("coll_set_wins", 32'(anomaly_flags), 32'h1);
    anomaly_clear = 4'h1;
    step();
    chk("coll_clear", 32'(anomaly_flags), 32'd0);
    found = 0;
    for (int n = 0; n < 60 && !found; n++) begin
      step();
      if (burst_done) found = 1;
    end
    chk("coll_done_seen", 32'(found), 32'd1);

    // Reset asserted in the cycle of ch1's tenth pop.
    do_reset();
    avail[1] = 40;
    found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      step();
      if (ch_pop[1] && pops[1] == 5) tree_anomaly = 1'b1;
      if (pops[1] == 10) found = 1;
    end
    chk("mid_pop10_seen", 32'(found), 32'd1);
    chk("mid_flag_before", 32'(anomaly_flags), 32'h2);
    reset = 1'b0;
    avail[0] = 5;
    step();
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_tree_rst_n", 32'(tree_rst_n), 32'd0);
    chk("mid_flags", 32'(anomaly_flags), 32'd0);
    chk("mid_grant", 32'(grant_ch), 32'd0);
    chk("mid_burst_done", 32'(burst_done), 32'd0);
    chk("mid_pop", 32'(ch_pop), 32'd0);
    chk("mid_fifo_kept", 32'(avail[1]), 32'd30);
    reset = 1'b1;
    found = 0;
    for (int n = 0; n < 10 && !found; n++) begin
      step();
      if (busy && !tree_rst_n) found = 1;
    end
    chk("mid_flush_seen", 32'(found), 32'd1);
    chk("mid_first_grant", 32'(grant_ch), 32'd0);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
